// File: rtl/sevenseg_scan_driver_if.sv
// Bundle of display-driver signals between the clock counters and the scan driver.
// Includes read-only debug taps of the scan state (prescaler and digit index).
interface sevenseg_scan_driver_if #(
  parameter int NUM_DIGITS  = 6,
  parameter int REFRESH_DIV = 50000
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // No valid/ready pair: en is a level qualifier. While en=1 the scan advances
  // every clock; the inputs are sampled only on the frame-start cycle.
  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_tick;
  logic [CNT_W-1:0]        dbg_cnt;
  logic [IDX_W-1:0]        dbg_idx;

  modport master (
    output en, digits_in, dp_in, blank_in,
    input  seg_out, dp_out, an_out, frame_tick, dbg_cnt, dbg_idx
  );

  modport slave (
    input  en, digits_in, dp_in, blank_in,
    output seg_out, dp_out, an_out, frame_tick, dbg_cnt, dbg_idx
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed seven-segment scan driver: one dead cycle per digit slot,
// one coherent snapshot of all digit inputs per frame, all outputs registered.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS     = 6,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit HEX_EN         = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  sevenseg_scan_driver_if.slave bus
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic                    en_prev_q, en_prev_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic                  load;
  logic [3:0]            code;
  logic                  dp_sel;
  logic                  blank_sel;
  logic [6:0]            seg_raw;
  logic                  dp_raw;
  logic [NUM_DIGITS-1:0] onehot;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = HEX_EN ? 7'h77 : 7'h00;
      4'hB: s = HEX_EN ? 7'h7C : 7'h00;
      4'hC: s = HEX_EN ? 7'h39 : 7'h00;
      4'hD: s = HEX_EN ? 7'h5E : 7'h00;
      4'hE: s = HEX_EN ? 7'h79 : 7'h00;
      default: s = HEX_EN ? 7'h71 : 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    snap_dig_d   = snap_dig_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    en_prev_d    = bus.en;
    seg_d        = seg_q;
    dp_d         = dp_q;
    an_d         = AN_OFF;
    tick_d       = 1'b0;

    load = bus.en && (cnt_q == '0) && (idx_q == '0);
    if (load) begin
      snap_dig_d   = bus.digits_in;
      snap_dp_d    = bus.dp_in;
      snap_blank_d = bus.blank_in;
    end

    // Decode from the next snapshot so digit 0 shows fresh data on the load cycle.
    code      = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      onehot[k] = (int'(idx_q) == k);
      if (int'(idx_q) == k) begin
        code      = snap_dig_d[4*k +: 4];
        dp_sel    = snap_dp_d[k];
        blank_sel = snap_blank_d[k];
      end
    end
    seg_raw = blank_sel ? 7'h00 : decode(code);
    dp_raw  = dp_sel & ~blank_sel;

    if (bus.en) begin
      tick_d = load;
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end

      // Slot start: anodes dark while the segment bus settles on the new digit.
      if (cnt_q == '0) begin
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        dp_d  = SEG_ACTIVE_LOW ? ~dp_raw : dp_raw;
      end else if (en_prev_q) begin
        an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_dig_q   <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      en_prev_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_dig_q   <= snap_dig_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      en_prev_q    <= en_prev_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.an_out     = an_q;
  assign bus.frame_tick = tick_q;
  assign bus.dbg_cnt    = cnt_q;
  assign bus.dbg_idx    = idx_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver: two instances (HEX_EN=0/1) share stimulus;
// a cycle model pushes expected outputs, which are popped and compared after each edge.
module tb_sevenseg_scan_driver;
  localparam int ND = 6;
  localparam int RD = 4;
  localparam int W  = 20;

  // clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          en;
  logic [23:0]   dig;
  logic [ND-1:0] dpv;
  logic [ND-1:0] blk;

  sevenseg_scan_driver_if #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) if0 ();
  sevenseg_scan_driver_if #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) if1 ();

  assign if0.en = en;  assign if0.digits_in = dig;  assign if0.dp_in = dpv;  assign if0.blank_in = blk;
  assign if1.en = en;  assign if1.digits_in = dig;  assign if1.dp_in = dpv;  assign if1.blank_in = blk;

  sevenseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1),
                         .AN_ACTIVE_LOW(1'b1), .HEX_EN(1'b0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  sevenseg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1),
                         .AN_ACTIVE_LOW(1'b1), .HEX_EN(1'b1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // scoreboard: word = {idx, cnt, an, seg, dp, frame_tick}
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int n_vec = 0;
  int n_err = 0;
  int n_cyc = 0;

  // model state
  int          m_slot, m_phase;
  logic        m_prev_en;
  logic [23:0] m_dig;
  logic [5:0]  m_dp, m_blk;
  logic [6:0]  m_seg[2];
  logic        m_dpo[2];

  function automatic logic [6:0] seg_hi(input logic [3:0] c, input bit hex);
    logic [6:0] t[16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    if (c > 4'd9 && !hex) return 7'h00;
    return t[c];
  endfunction

  task automatic model_reset();
    m_slot = 0;  m_phase = 0;  m_prev_en = 1'b0;
    m_dig = '0;  m_dp = '0;  m_blk = '0;
    for (int h = 0; h < 2; h++) begin
      m_seg[h] = 7'h7F;
      m_dpo[h] = 1'b1;
    end
  endtask

  // Expected outputs after the next rising edge, given the inputs now driven.
  task automatic model_edge(output logic [W-1:0] w0, output logic [W-1:0] w1);
    logic       ft;
    logic [5:0] an;
    logic [6:0] s;
    ft = 1'b0;
    an = 6'h3F;
    if (en) begin
      if (m_phase == 0 && m_slot == 0) begin
        m_dig = dig;  m_dp = dpv;  m_blk = blk;  ft = 1'b1;
      end
      if (m_phase == 0) begin
        for (int h = 0; h < 2; h++) begin
          s = m_blk[m_slot] ? 7'h00 : seg_hi(m_dig[4*m_slot +: 4], h == 1);
          m_seg[h] = ~s;
          m_dpo[h] = ~(m_dp[m_slot] & ~m_blk[m_slot]);
        end
      end
      if (m_phase != 0 && m_prev_en) an = ~(6'b1 << m_slot);
      if (m_phase == RD - 1) begin
        m_phase = 0;
        m_slot  = (m_slot + 1) % ND;
      end else begin
        m_phase = m_phase + 1;
      end
    end
    m_prev_en = en;
    w0 = {3'(m_slot), 2'(m_phase), an, m_seg[0], m_dpo[0], ft};
    w1 = {3'(m_slot), 2'(m_phase), an, m_seg[1], m_dpo[1], ft};
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("miscompare %s", tag);
    end
  endtask

  task automatic pop_compare(input string tag);
    logic [W-1:0] o0, o1;
    o0 = {if0.dbg_idx, if0.dbg_cnt, if0.an_out, if0.seg_out, if0.dp_out, if0.frame_tick};
    o1 = {if1.dbg_idx, if1.dbg_cnt, if1.an_out, if1.seg_out, if1.dp_out, if1.frame_tick};
    check($sformatf("%s dut0", tag), o0, exp_q0.pop_front());
    check($sformatf("%s dut1", tag), o1, exp_q1.pop_front());
  endtask

  // driver: one clock of stimulus with its expected result queued
  task automatic cycle();
    logic [W-1:0] w0, w1;
    model_edge(w0, w1);
    exp_q0.push_back(w0);
    exp_q1.push_back(w1);
    @(posedge clk);
    #1;
    n_cyc++;
    pop_compare($sformatf("cyc%0d", n_cyc));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic expect_reset(input string tag);
    exp_q0.push_back({3'd0, 2'd0, 6'h3F, 7'h7F, 1'b1, 1'b0});
    exp_q1.push_back({3'd0, 2'd0, 6'h3F, 7'h7F, 1'b1, 1'b0});
    pop_compare(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    dig   = 24'h543210;
    dpv   = '0;
    blk   = '0;
    model_reset();

    // reset defaults held over several edges
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      expect_reset($sformatf("reset%0d", i));
    end

    // decode sweep: two full frames
    rst_n = 1'b1;
    run(2 * ND * RD);

    // frame coherence: change inputs at idx=2, then finish this frame and one more
    run(2 * RD);
    dig = 24'h999999;
    run(4 * RD + ND * RD);

    // blank, dp and hex digit at a frame boundary
    dig = 24'h99999A;
    dpv = 6'b000001;
    blk = 6'b000010;
    run(ND * RD);

    // enable gating at idx=3, cnt=2
    run(3 * RD + 2);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(ND * RD);

    // asynchronous reset between edges, then restart from digit 0
    run(5);
    #2 rst_n = 1'b0;
    #1 expect_reset("async_reset");
    model_reset();
    #1 rst_n = 1'b1;
    run(ND * RD + 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
